axi_ctrl_host_arbiter: RTL and testbench

- Two-requester arbiter and transaction sequencer in front of the buffered heater/odometer control AXI slave.
- Slave channels: AW, W, AR and R; no B channel, since the slave's BREADY is tied high.
- Turns single-word read/write commands from two hosts (M0: scan/JTAG bridge, M1: on-chip test sequencer) into AXI channel handshakes.
- Round-robin fairness between the hosts; per-transaction timeout; recovery of late read data.

---
 rtl/axi_ctrl_host_arbiter.sv | 252 +++++++++++++++++++++++++
 tb/tb_axi_ctrl_host_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ctrl_host_arbiter.sv
// Two-host round-robin arbiter that sequences single-word commands onto AXI AW/W/AR/R.
// Each transaction has a timeout; read beats that arrive after a read timed out are drained.
`timescale 1ns/1ps
module axi_ctrl_host_arbiter #(
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int C_S_AXI_DATA_WIDTH = 8,
  parameter int TIMEOUT_CYCLES     = 255,
  parameter int TIMEOUT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic                          M0_REQ_VALID,
  output logic                          M0_REQ_READY,
  input  logic                          M0_REQ_WRITE,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] M0_REQ_ADDR,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] M0_REQ_WDATA,
  output logic                          M0_RSP_VALID,
  output logic [C_S_AXI_DATA_WIDTH-1:0] M0_RSP_RDATA,
  output logic                          M0_RSP_ERR,
  input  logic                          M1_REQ_VALID,
  output logic                          M1_REQ_READY,
  input  logic                          M1_REQ_WRITE,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] M1_REQ_ADDR,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] M1_REQ_WDATA,
  output logic                          M1_RSP_VALID,
  output logic [C_S_AXI_DATA_WIDTH-1:0] M1_RSP_RDATA,
  output logic                          M1_RSP_ERR,
  output logic [C_S_AXI_ADDR_WIDTH-1:0] AWADDR,
  output logic                          AWVALID,
  input  logic                          AWREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0] WDATA,
  output logic                          WVALID,
  input  logic                          WREADY,
  output logic [C_S_AXI_ADDR_WIDTH-1:0] ARADDR,
  output logic                          ARVALID,
  input  logic                          ARREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] RDATA,
  input  logic                          RVALID,
  output logic                          RREADY,
  output logic                          BUSY,
  output logic                          LAST_GRANT
);

  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam logic [TIMEOUT_WIDTH-1:0] TO_MAX  = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD_A, S_RD_D, S_RESP} state_t;

  state_t                   r_state;
  logic                     r_host;
  logic                     r_last_grant;
  logic                     r_busy;
  logic                     r_awvalid;
  logic                     r_wvalid;
  logic                     r_arvalid;
  logic                     r_rready;
  logic                     r_aw_done;
  logic                     r_w_done;
  logic [AW-1:0]            r_awaddr;
  logic [AW-1:0]            r_araddr;
  logic [DW-1:0]            r_wdata;
  logic [TIMEOUT_WIDTH-1:0] r_cnt;
  logic [1:0]               r_drop;
  logic [1:0]               r_rsp_vld;
  logic [1:0]               r_rsp_err;
  logic [1:0][DW-1:0]       r_rsp_rdata;

  logic          w_idle_ok;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_accept;
  logic          w_sel;
  logic          w_write;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic          w_aw_hs;
  logic          w_w_hs;
  logic          w_ar_hs;
  logic          w_r_hs;
  logic          w_aw_fin;
  logic          w_w_fin;
  logic          w_timeout;

  // On a tie the host that did not win last time gets the grant.
  assign w_idle_ok    = (r_state == S_IDLE) && (r_drop == 2'd0);
  assign w_gnt0       = M0_REQ_VALID && (!M1_REQ_VALID || r_last_grant);
  assign w_gnt1       = M1_REQ_VALID && (!M0_REQ_VALID || !r_last_grant);
  assign M0_REQ_READY = w_idle_ok && w_gnt0;
  assign M1_REQ_READY = w_idle_ok && w_gnt1;

  assign w_accept = M0_REQ_READY || M1_REQ_READY;
  assign w_sel    = M1_REQ_READY;
  assign w_write  = w_sel ? M1_REQ_WRITE : M0_REQ_WRITE;
  assign w_addr   = w_sel ? M1_REQ_ADDR  : M0_REQ_ADDR;
  assign w_wdata  = w_sel ? M1_REQ_WDATA : M0_REQ_WDATA;

  assign w_aw_hs   = r_awvalid && AWREADY;
  assign w_w_hs    = r_wvalid && WREADY;
  assign w_ar_hs   = r_arvalid && ARREADY;
  assign w_r_hs    = r_rready && RVALID;
  assign w_aw_fin  = r_aw_done || w_aw_hs;
  assign w_w_fin   = r_w_done || w_w_hs;
  assign w_timeout = (r_cnt >= TO_LAST);

  assign AWADDR       = r_awaddr;
  assign AWVALID      = r_awvalid;
  assign WDATA        = r_wdata;
  assign WVALID       = r_wvalid;
  assign ARADDR       = r_araddr;
  assign ARVALID      = r_arvalid;
  assign RREADY       = r_rready;
  assign BUSY         = r_busy;
  assign LAST_GRANT   = r_last_grant;
  assign M0_RSP_VALID = r_rsp_vld[0];
  assign M0_RSP_ERR   = r_rsp_err[0];
  assign M0_RSP_RDATA = r_rsp_rdata[0];
  assign M1_RSP_VALID = r_rsp_vld[1];
  assign M1_RSP_ERR   = r_rsp_err[1];
  assign M1_RSP_RDATA = r_rsp_rdata[1];

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state      <= S_IDLE;
      r_host       <= 1'b0;
      r_last_grant <= 1'b1;
      r_busy       <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_awaddr     <= '0;
      r_araddr     <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_drop       <= 2'd0;
      r_rsp_vld    <= '0;
      r_rsp_err    <= '0;
      r_rsp_rdata  <= '0;
    end else begin
      // Saturating so a transaction that ran past its deadline still times out.
      if ((r_state == S_WR || r_state == S_RD_A || r_state == S_RD_D) && (r_cnt != TO_MAX))
        r_cnt <= r_cnt + TIMEOUT_WIDTH'(1);

      case (r_state)
        S_IDLE: begin
          if (r_drop != 2'd0) begin
            if (w_r_hs) begin
              r_drop   <= r_drop - 2'd1;
              r_rready <= (r_drop != 2'd1);
            end else begin
              r_rready <= 1'b1;
            end
          end else begin
            r_rready <= 1'b0;
            if (w_accept) begin
              r_host       <= w_sel;
              r_last_grant <= w_sel;
              r_cnt        <= '0;
              r_busy       <= 1'b1;
              if (w_write) begin
                r_state   <= S_WR;
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
                r_awaddr  <= w_addr;
                r_wdata   <= w_wdata;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
              end else begin
                r_state   <= S_RD_A;
                r_arvalid <= 1'b1;
                r_araddr  <= w_addr;
              end
            end
          end
        end

        S_WR: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_fin && w_w_fin) begin
            r_state             <= S_RESP;
            r_rsp_vld[r_host]   <= 1'b1;
            r_rsp_err[r_host]   <= 1'b0;
            r_rsp_rdata[r_host] <= '0;
          end else if (w_timeout) begin
            r_awvalid           <= 1'b0;
            r_wvalid            <= 1'b0;
            r_state             <= S_RESP;
            r_rsp_vld[r_host]   <= 1'b1;
            r_rsp_err[r_host]   <= 1'b1;
            r_rsp_rdata[r_host] <= '0;
          end
        end

        S_RD_A: begin
          if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_D;
          end else if (w_timeout) begin
            r_arvalid           <= 1'b0;
            r_state             <= S_RESP;
            r_rsp_vld[r_host]   <= 1'b1;
            r_rsp_err[r_host]   <= 1'b1;
            r_rsp_rdata[r_host] <= '0;
          end
        end

        S_RD_D: begin
          if (w_r_hs) begin
            r_rready            <= 1'b0;
            r_state             <= S_RESP;
            r_rsp_vld[r_host]   <= 1'b1;
            r_rsp_err[r_host]   <= 1'b0;
            r_rsp_rdata[r_host] <= RDATA;
          end else if (w_timeout) begin
            // The slave still owes a beat for this read; remember to swallow it.
            r_rready            <= 1'b0;
            if (r_drop != 2'd3)
              r_drop <= r_drop + 2'd1;
            r_state             <= S_RESP;
            r_rsp_vld[r_host]   <= 1'b1;
            r_rsp_err[r_host]   <= 1'b1;
            r_rsp_rdata[r_host] <= '0;
          end
        end

        S_RESP: begin
          r_rsp_vld   <= '0;
          r_rsp_err   <= '0;
          r_rsp_rdata <= '0;
          r_busy      <= 1'b0;
          r_rready    <= (r_drop != 2'd0);
          r_state     <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ctrl_host_arbiter.sv
// Directed bench for axi_ctrl_host_arbiter with a response scoreboard.
`timescale 1ns/1ps
module tb_axi_ctrl_host_arbiter;
  localparam int AW = 6;
  localparam int DW = 8;
  localparam int TO = 8;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          M0_REQ_VALID, M0_REQ_READY, M0_REQ_WRITE;
  logic [AW-1:0] M0_REQ_ADDR;
  logic [DW-1:0] M0_REQ_WDATA;
  logic          M0_RSP_VALID, M0_RSP_ERR;
  logic [DW-1:0] M0_RSP_RDATA;
  logic          M1_REQ_VALID, M1_REQ_READY, M1_REQ_WRITE;
  logic [AW-1:0] M1_REQ_ADDR;
  logic [DW-1:0] M1_REQ_WDATA;
  logic          M1_RSP_VALID, M1_RSP_ERR;
  logic [DW-1:0] M1_RSP_RDATA;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [DW-1:0] WDATA, RDATA;
  logic          AWVALID, AWREADY, WVALID, WREADY, ARVALID, ARREADY, RVALID, RREADY;
  logic          BUSY, LAST_GRANT;

  typedef struct packed {
    logic          host;
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   rsp_cnt = 0;
  int   n_rsp_exp = 0;
  int   k;
  int   b;

  always #5 ACLK = ~ACLK;

  axi_ctrl_host_arbiter #(
    .C_S_AXI_ADDR_WIDTH(AW),
    .C_S_AXI_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .M0_REQ_VALID(M0_REQ_VALID), .M0_REQ_READY(M0_REQ_READY), .M0_REQ_WRITE(M0_REQ_WRITE),
    .M0_REQ_ADDR(M0_REQ_ADDR), .M0_REQ_WDATA(M0_REQ_WDATA),
    .M0_RSP_VALID(M0_RSP_VALID), .M0_RSP_RDATA(M0_RSP_RDATA), .M0_RSP_ERR(M0_RSP_ERR),
    .M1_REQ_VALID(M1_REQ_VALID), .M1_REQ_READY(M1_REQ_READY), .M1_REQ_WRITE(M1_REQ_WRITE),
    .M1_REQ_ADDR(M1_REQ_ADDR), .M1_REQ_WDATA(M1_REQ_WDATA),
    .M1_RSP_VALID(M1_RSP_VALID), .M1_RSP_RDATA(M1_RSP_RDATA), .M1_RSP_ERR(M1_RSP_ERR),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY),
    .BUSY(BUSY), .LAST_GRANT(LAST_GRANT)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic h, input logic e, input logic [DW-1:0] d);
    exp_t r;
    r.host = h; r.err = e; r.rdata = d;
    return r;
  endfunction

  task automatic push(input exp_t e);
    sb.push_back(e);
    n_rsp_exp++;
  endtask

  task automatic drive(input logic h, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (h) begin
      M1_REQ_VALID = 1'b1; M1_REQ_WRITE = wr; M1_REQ_ADDR = a; M1_REQ_WDATA = d;
    end else begin
      M0_REQ_VALID = 1'b1; M0_REQ_WRITE = wr; M0_REQ_ADDR = a; M0_REQ_WDATA = d;
    end
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int n;
    n = 0;
    while (rsp_cnt < target && n < budget) begin
      @(negedge ACLK); #1;
      n++;
    end
    chk("wait_rsp", rsp_cnt, target);
  endtask

  // Every response pulse is matched against the oldest outstanding expectation.
  always @(negedge ACLK) begin
    if (!ARESET && (M0_RSP_VALID || M1_RSP_VALID)) begin
      rsp_cnt++;
      chk("rsp_expected", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("rsp_host", {M1_RSP_VALID, M0_RSP_VALID}, mon_e.host ? 2'b10 : 2'b01);
        chk("rsp_rdata", mon_e.host ? M1_RSP_RDATA : M0_RSP_RDATA, mon_e.rdata);
        chk("rsp_err", mon_e.host ? M1_RSP_ERR : M0_RSP_ERR, mon_e.err);
        chk("rsp_other_silent", mon_e.host ? {M0_RSP_ERR, M0_RSP_RDATA} : {M1_RSP_ERR, M1_RSP_RDATA}, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ARESET = 1'b1;
    M0_REQ_VALID = 0; M0_REQ_WRITE = 0; M0_REQ_ADDR = 0; M0_REQ_WDATA = 0;
    M1_REQ_VALID = 0; M1_REQ_WRITE = 0; M1_REQ_ADDR = 0; M1_REQ_WDATA = 0;
    AWREADY = 0; WREADY = 0; ARREADY = 0; RVALID = 0; RDATA = 0;

    // Reset state
    @(negedge ACLK);
    chk("rst_ctrl", {AWVALID, WVALID, ARVALID, RREADY, BUSY, LAST_GRANT, M0_RSP_VALID, M1_RSP_VALID}, 8'b0000_0100);
    chk("rst_data", {AWADDR, WDATA, ARADDR}, 0);
    chk("rst_rsp", {M0_RSP_RDATA, M1_RSP_RDATA, M0_RSP_ERR, M1_RSP_ERR}, 0);
    ARESET = 1'b0;
    @(negedge ACLK);

    // Write, slave always ready
    AWREADY = 1; WREADY = 1; ARREADY = 1;
    drive(0, 1, 6'h05, 8'hA5);
    #1;
    chk("t1_m0_rdy", M0_REQ_READY, 1);
    chk("t1_m1_rdy", M1_REQ_READY, 0);
    push(mk(0, 0, 8'h00));
    @(negedge ACLK); M0_REQ_VALID = 0;
    chk("t1_valids", {AWVALID, WVALID, BUSY}, 3'b111);
    chk("t1_awaddr", AWADDR, 6'h05);
    chk("t1_wdata", WDATA, 8'hA5);
    @(negedge ACLK);
    chk("t1_rsp_t2", {M1_RSP_VALID, M0_RSP_VALID}, 2'b01);
    chk("t1_valids_drop", {AWVALID, WVALID}, 2'b00);
    @(negedge ACLK);
    chk("t1_done", {BUSY, M0_RSP_VALID}, 2'b00);

    // Read with AR back-pressure
    ARREADY = 0;
    drive(1, 0, 6'h10, 8'h00);
    #1;
    chk("t2_m1_rdy", M1_REQ_READY, 1);
    push(mk(1, 0, 8'h3C));
    @(negedge ACLK); M1_REQ_VALID = 0;
    chk("t2_arvalid", ARVALID, 1);
    chk("t2_araddr", ARADDR, 6'h10);
    @(negedge ACLK);
    chk("t2_ar_hold", ARVALID, 1);
    @(negedge ACLK); ARREADY = 1;
    @(negedge ACLK); ARREADY = 0;
    chk("t2_ar_rready", {ARVALID, RREADY}, 2'b01);
    @(negedge ACLK); RVALID = 1; RDATA = 8'h3C;
    @(negedge ACLK); RVALID = 0; RDATA = 0;
    chk("t2_rsp", {M1_RSP_VALID, M0_RSP_VALID, RREADY}, 3'b100);
    @(negedge ACLK);
    chk("t2_rsp_pulse", M1_RSP_VALID, 0);

    // Fairness from reset with both hosts continuously valid
    ARESET = 1;
    @(negedge ACLK); ARESET = 0;
    AWREADY = 1; WREADY = 1; ARREADY = 1;
    drive(0, 1, 6'h01, 8'h11);
    drive(1, 1, 6'h02, 8'h22);
    for (int i = 0; i < 4; i++) begin
      b = 0;
      #1;
      while (!(M0_REQ_READY || M1_REQ_READY) && b < 10) begin
        @(negedge ACLK); #1;
        b++;
      end
      chk("fair_m0_rdy", M0_REQ_READY, (i % 2 == 0));
      chk("fair_m1_rdy", M1_REQ_READY, (i % 2 == 1));
      push(mk(i % 2 == 1, 0, 8'h00));
      @(posedge ACLK);
      @(negedge ACLK);
      chk("fair_last_grant", LAST_GRANT, (i % 2 == 1));
      chk("fair_awaddr", AWADDR, (i % 2 == 1) ? 6'h02 : 6'h01);
      chk("fair_wdata", WDATA, (i % 2 == 1) ? 8'h22 : 8'h11);
    end
    M0_REQ_VALID = 0; M1_REQ_VALID = 0;
    wait_rsp(n_rsp_exp, 20);

    // Split write: W completes four cycles before AW
    @(negedge ACLK);
    AWREADY = 0; WREADY = 1;
    drive(0, 1, 6'h2A, 8'h5A);
    #1;
    chk("t4_m0_rdy", M0_REQ_READY, 1);
    push(mk(0, 0, 8'h00));
    @(negedge ACLK); M0_REQ_VALID = 0;
    chk("t4_both_valid", {AWVALID, WVALID}, 2'b11);
    for (int j = 0; j < 3; j++) begin
      @(negedge ACLK);
      chk("t4_aw_only", {AWVALID, WVALID}, 2'b10);
    end
    @(negedge ACLK); AWREADY = 1;
    @(negedge ACLK); AWREADY = 0;
    chk("t4_rsp", {AWVALID, M0_RSP_VALID}, 2'b01);
    @(negedge ACLK); #1;
    chk("t4_single_rsp", rsp_cnt, n_rsp_exp);
    AWREADY = 1;

    // Read timeout, late beat drained, pending M0 held off
    RVALID = 0; ARREADY = 1;
    drive(1, 0, 6'h33, 8'h00);
    #1;
    chk("t5_m1_rdy", M1_REQ_READY, 1);
    push(mk(1, 1, 8'h00));
    @(negedge ACLK); M1_REQ_VALID = 0;
    k = 1;
    while (!M1_RSP_VALID && k < 12) begin
      @(negedge ACLK);
      k++;
    end
    chk("t5_to_latency", k, TO + 1);
    chk("t5_to_err", M1_RSP_ERR, 1);
    drive(0, 0, 6'h07, 8'h00);
    #1;
    chk("t5_m0_block_resp", M0_REQ_READY, 0);
    @(negedge ACLK); #1;
    chk("t5_drain", {RREADY, BUSY, M0_REQ_READY}, 3'b100);
    @(negedge ACLK); #1;
    chk("t5_m0_held", M0_REQ_READY, 0);
    RVALID = 1; RDATA = 8'h77;
    @(negedge ACLK); RVALID = 0; RDATA = 0;
    #1;
    chk("t5_drain_done", {RREADY, M0_REQ_READY}, 2'b01);
    chk("t5_drop_no_rsp", rsp_cnt, n_rsp_exp);
    push(mk(0, 0, 8'h99));
    @(negedge ACLK); M0_REQ_VALID = 0;
    chk("t5_m0_ar", ARADDR, 6'h07);
    @(negedge ACLK);
    chk("t5_m0_rready", RREADY, 1);
    RVALID = 1; RDATA = 8'h99;
    @(negedge ACLK); RVALID = 0; RDATA = 0;
    chk("t5_m0_rsp", M0_RSP_VALID, 1);

    // Reset in the middle of a read
    @(negedge ACLK);
    drive(1, 0, 6'h11, 8'h00);
    #1;
    chk("t6_m1_rdy", M1_REQ_READY, 1);
    push(mk(1, 0, 8'h00));
    @(negedge ACLK); M1_REQ_VALID = 0;
    @(negedge ACLK);
    chk("t6_in_rd_d", {RREADY, BUSY}, 2'b11);
    #1 ARESET = 1;
    #1;
    chk("t6_rst_ctrl", {AWVALID, WVALID, ARVALID, RREADY, BUSY, LAST_GRANT, M0_RSP_VALID, M1_RSP_VALID}, 8'b0000_0100);
    chk("t6_rst_data", {AWADDR, WDATA, ARADDR}, 0);
    sb.delete();
    n_rsp_exp--;
    @(negedge ACLK);
    @(negedge ACLK); ARESET = 0;
    #1;
    chk("t6_no_rsp", rsp_cnt, n_rsp_exp);
    drive(0, 1, 6'h3F, 8'hC3);
    #1;
    chk("t6_m0_rdy", M0_REQ_READY, 1);
    push(mk(0, 0, 8'h00));
    @(negedge ACLK); M0_REQ_VALID = 0;
    chk("t6_awaddr", AWADDR, 6'h3F);
    chk("t6_wdata", WDATA, 8'hC3);
    wait_rsp(n_rsp_exp, 10);

    @(negedge ACLK);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
